// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero short-circuits straight to DONE
// with quotient all ones and remainder equal to the dividend.
module seq_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_q;
    // Partial remainder. Its top bit is always 0 after a step (it is either a
    // non-negative trial result or a restored value below the divisor), so
    // only the low WIDTH bits are stored.
    logic [WIDTH-1:0] r_rem;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;

    // One restoring step: shift in the next dividend bit and try to subtract.
    always_comb begin
        w_shift    = {1'b0, r_rem, r_q[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_divisor};
        w_rem_next = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_q_next   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_count       <= '0;
            r_divisor     <= '0;
            r_q           <= '0;
            r_rem         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_divisor <= i_divisor;
                        if (i_divisor == '0) begin
                            r_quotient    <= '1;
                            r_remainder   <= i_dividend;
                            r_div_by_zero <= 1'b1;
                            r_done        <= 1'b1;
                            r_state       <= StDone;
                        end else begin
                            r_q     <= i_dividend;
                            r_rem   <= '0;
                            r_count <= '0;
                            r_busy  <= 1'b1;
                            r_state <= StRun;
                        end
                    end
                end
                StRun: begin
                    r_q     <= w_q_next;
                    r_rem   <= w_rem_next;
                    r_count <= r_count + CW'(1);
                    if (r_count == LastIter) begin
                        r_quotient    <= w_q_next;
                        r_remainder   <= w_rem_next;
                        r_div_by_zero <= 1'b0;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_quotient    = r_quotient;
    assign o_remainder   = r_remainder;
    assign o_div_by_zero = r_div_by_zero;

endmodule
